// File: rtl/ext_mem_dual_channel_model.sv
// Dual-channel byte-wide external memory slave with programmable read/write latency.
// Optional access counters are enabled by defining EXT_MEM_ACCESS_CNT_EN.
module ext_mem_dual_channel_model #(
  parameter int ADDR_W      = 7,
  parameter int MEMSIZE     = 64,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Mout_oe_ram,
  input  logic [1:0]          Mout_we_ram,
  input  logic [2*ADDR_W-1:0] Mout_addr_ram,
  input  logic [15:0]         Mout_Wdata_ram,
  input  logic [7:0]          Mout_data_ram_size,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [7:0]          load_data,
  output logic [15:0]         M_Rdata_ram,
  output logic [1:0]          M_DataRdy,
  output logic                proto_err,
  output logic [3:0]          dbg_state
`ifdef EXT_MEM_ACCESS_CNT_EN
  ,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count
`endif
);

  // Handshake: a channel request (oe or we) is accepted only from IDLE at a rising
  // edge; the master holds it until M_DataRdy, which pulses for exactly one cycle.

  localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [32:0] BASE_EXT = 33'(BASE_ADDR);
  localparam logic [31:0] MEM_SZ   = 32'(MEMSIZE);
  localparam logic [15:0] RD_CNT   = 16'(READ_DELAY);
  localparam logic [15:0] WR_CNT   = 16'(WRITE_DELAY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_e;

  state_e      state_q [2];
  logic [15:0] cnt_q   [2];
  logic [7:0]  hold_q  [2];
  logic        proto_err_q;

  logic [7:0]  mem [MEMSIZE];

  logic [ADDR_W-1:0] addr_c [2];
  logic [32:0]       off_c  [2];
  logic [IDX_W-1:0]  idx_c  [2];
  logic [7:0]        mask_c [2];
  logic [7:0]        wdat_c [2];
  logic [3:0]        size_c [2];
  logic [1:0]        in_range;
  logic [1:0]        rd_acc;
  logic [1:0]        wr_acc;
  logic [1:0]        rdy;
  logic              all_idle;
  logic              load_in_range;
  logic              load_ok;
  logic              load_err;
  logic [IDX_W-1:0]  load_idx;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      addr_c[c]   = Mout_addr_ram[c*ADDR_W +: ADDR_W];
      // Offset is computed one bit wider so addresses below BASE_ADDR show up as negative.
      off_c[c]    = 33'(addr_c[c]) - BASE_EXT;
      in_range[c] = !off_c[c][32] && (off_c[c][31:0] < MEM_SZ);
      idx_c[c]    = off_c[c][IDX_W-1:0];
      size_c[c]   = Mout_data_ram_size[c*4 +: 4];
      wdat_c[c]   = Mout_Wdata_ram[c*8 +: 8];
      mask_c[c]   = (size_c[c] >= 4'd8) ? 8'hFF : 8'((9'd1 << size_c[c]) - 9'd1);
      rd_acc[c]   = (state_q[c] == IDLE) && Mout_oe_ram[c] && !Mout_we_ram[c] && in_range[c];
      wr_acc[c]   = (state_q[c] == IDLE) && Mout_we_ram[c] && !Mout_oe_ram[c] && in_range[c];
      rdy[c]      = ((state_q[c] == RD_WAIT) && (cnt_q[c] == RD_CNT)) ||
                    ((state_q[c] == WR_WAIT) && (cnt_q[c] == WR_CNT));
    end
    all_idle      = (state_q[0] == IDLE) && (state_q[1] == IDLE);
    load_in_range = 32'(load_addr) < MEM_SZ;
    load_idx      = load_addr[IDX_W-1:0];
    load_ok       = load_en && load_in_range && all_idle && !(|rd_acc) && !(|wr_acc);
    load_err      = load_en && load_in_range && !load_ok;
  end

  assign M_DataRdy   = rdy;
  assign M_Rdata_ram = {rdy[1] ? hold_q[1] : 8'h00, rdy[0] ? hold_q[0] : 8'h00};
  assign proto_err   = proto_err_q;
  assign dbg_state   = {state_q[1], state_q[0]};

  // Array has no reset; writes are suppressed while reset is held so that a request
  // present during reset cannot commit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (load_ok) begin
        mem[load_idx] <= load_data;
      end
      // Channel 1 is applied last so it wins a same-byte collision.
      for (int c = 0; c < 2; c++) begin
        if (wr_acc[c]) begin
          mem[idx_c[c]] <= (wdat_c[c] & mask_c[c]) | (mem[idx_c[c]] & ~mask_c[c]);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        hold_q[c]  <= '0;
      end
      proto_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        case (state_q[c])
          IDLE: begin
            if (rd_acc[c]) begin
              hold_q[c]  <= mem[idx_c[c]];
              cnt_q[c]   <= 16'd1;
              state_q[c] <= RD_WAIT;
            end else if (wr_acc[c]) begin
              cnt_q[c]   <= 16'd1;
              state_q[c] <= WR_WAIT;
            end
          end
          RD_WAIT, WR_WAIT: begin
            if (rdy[c]) begin
              cnt_q[c]   <= '0;
              state_q[c] <= IDLE;
            end else begin
              cnt_q[c] <= cnt_q[c] + 16'd1;
            end
          end
          default: begin
            cnt_q[c]   <= '0;
            state_q[c] <= IDLE;
          end
        endcase
      end
      if ((|(Mout_oe_ram & Mout_we_ram)) || load_err) begin
        proto_err_q <= 1'b1;
      end
    end
  end

`ifdef EXT_MEM_ACCESS_CNT_EN
  logic [31:0] rd_count_q;
  logic [31:0] wr_count_q;
  logic [32:0] rd_sum;
  logic [32:0] wr_sum;

  always_comb begin
    rd_sum = {1'b0, rd_count_q} + 33'(rd_acc[0]) + 33'(rd_acc[1]);
    wr_sum = {1'b0, wr_count_q} + 33'(wr_acc[0]) + 33'(wr_acc[1]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_sum[32] ? 32'hFFFF_FFFF : rd_sum[31:0];
      wr_count_q <= wr_sum[32] ? 32'hFFFF_FFFF : wr_sum[31:0];
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ext_mem_dual_channel_model.sv
// Directed bench for ext_mem_dual_channel_model (READ_DELAY=2, WRITE_DELAY=1, MEMSIZE=64).
module tb_ext_mem_dual_channel_model;

  logic        clock;
  logic        reset;
  logic [1:0]  Mout_oe_ram;
  logic [1:0]  Mout_we_ram;
  logic [13:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;
  logic        load_en;
  logic [6:0]  load_addr;
  logic [7:0]  load_data;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic        proto_err;
  logic [3:0]  dbg_state;
`ifdef EXT_MEM_ACCESS_CNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int total = 0;
  int bad   = 0;

  ext_mem_dual_channel_model dut (
    .clock              (clock),
    .reset              (reset),
    .Mout_oe_ram        (Mout_oe_ram),
    .Mout_we_ram        (Mout_we_ram),
    .Mout_addr_ram      (Mout_addr_ram),
    .Mout_Wdata_ram     (Mout_Wdata_ram),
    .Mout_data_ram_size (Mout_data_ram_size),
    .load_en            (load_en),
    .load_addr          (load_addr),
    .load_data          (load_data),
    .M_Rdata_ram        (M_Rdata_ram),
    .M_DataRdy          (M_DataRdy),
    .proto_err          (proto_err),
    .dbg_state          (dbg_state)
`ifdef EXT_MEM_ACCESS_CNT_EN
    ,
    .rd_count           (rd_count),
    .wr_count           (wr_count)
`endif
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic set_addr(input int ch, input logic [6:0] a);
    Mout_addr_ram[ch*7 +: 7] = a;
  endtask

  task automatic do_read(input int ch, input logic [6:0] a, input logic [7:0] exp, input string tag);
    Mout_oe_ram[ch] = 1'b1;
    set_addr(ch, a);
    tick();
    chk({tag, "_wait"}, 32'(M_DataRdy), 32'd0);
    tick();
    chk({tag, "_rdy"}, 32'(M_DataRdy), 32'd1 << ch);
    chk({tag, "_data"}, 32'(M_Rdata_ram), 32'(exp) << (8 * ch));
    Mout_oe_ram[ch] = 1'b0;
    tick();
    chk({tag, "_done"}, {14'd0, M_DataRdy, M_Rdata_ram}, 32'd0);
  endtask

  task automatic do_write(input int ch, input logic [6:0] a, input logic [7:0] d,
                          input logic [3:0] sz, input string tag);
    Mout_we_ram[ch] = 1'b1;
    set_addr(ch, a);
    Mout_Wdata_ram[ch*8 +: 8]     = d;
    Mout_data_ram_size[ch*4 +: 4] = sz;
    tick();
    chk({tag, "_rdy"}, 32'(M_DataRdy), 32'd1 << ch);
    Mout_we_ram[ch] = 1'b0;
    tick();
    chk({tag, "_done"}, 32'(M_DataRdy), 32'd0);
  endtask

  initial begin
    int seen;
    reset              = 1'b1;
    Mout_oe_ram        = '0;
    Mout_we_ram        = '0;
    Mout_addr_ram      = '0;
    Mout_Wdata_ram     = '0;
    Mout_data_ram_size = '0;
    load_en            = 1'b0;
    load_addr          = '0;
    load_data          = '0;
    @(negedge clock);
    tick();
    tick();
    chk("rst_rdy", 32'(M_DataRdy), 32'd0);
    chk("rst_rdata", 32'(M_Rdata_ram), 32'd0);
    chk("rst_err", 32'(proto_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // Preload and basic read, channel 0
    preload(7'd5, 8'hA5);
    preload(7'd3, 8'hFF);
    preload(7'd36, 8'h12);
    do_read(0, 7'd5, 8'hA5, "rd5");

    // Held request across DataRdy is not re-accepted on the edge ending it
    Mout_oe_ram[0] = 1'b1;
    set_addr(0, 7'd5);
    tick();
    chk("b2b_acc_state", 32'(dbg_state[1:0]), 32'd1);
    tick();
    chk("b2b_rdy1", 32'(M_DataRdy), 32'd1);
    tick();
    chk("b2b_gap_rdy", 32'(M_DataRdy), 32'd0);
    chk("b2b_gap_state", 32'(dbg_state[1:0]), 32'd0);
    tick();
    chk("b2b_reacc_state", 32'(dbg_state[1:0]), 32'd1);
    chk("b2b_reacc_rdy", 32'(M_DataRdy), 32'd0);
    tick();
    chk("b2b_rdy2", 32'(M_DataRdy), 32'd1);
    chk("b2b_data2", 32'(M_Rdata_ram), 32'h00A5);
    Mout_oe_ram[0] = 1'b0;
    tick();

    // Masked write: 0xFF with 0x00 size 4 -> 0xF0
    do_write(1, 7'd3, 8'h00, 4'd4, "wr3_mask");
    do_read(1, 7'd3, 8'hF0, "rd3_mask");
    // size >= 8 writes the full byte
    do_write(0, 7'd3, 8'h3C, 4'd12, "wr3_full");
    do_read(1, 7'd3, 8'h3C, "rd3_full");

    // Same-byte collision: channel 1 wins, both complete
    Mout_we_ram    = 2'b11;
    Mout_addr_ram  = {7'd9, 7'd9};
    Mout_Wdata_ram = 16'h2211;
    Mout_data_ram_size = 8'h88;
    tick();
    chk("coll_rdy", 32'(M_DataRdy), 32'd3);
    Mout_we_ram = 2'b00;
    tick();
    chk("coll_done", 32'(M_DataRdy), 32'd0);
    do_read(0, 7'd9, 8'h22, "coll_rd");

    // Read and write of the same byte on one edge: read sees the old value
    Mout_oe_ram    = 2'b01;
    Mout_we_ram    = 2'b10;
    Mout_addr_ram  = {7'd9, 7'd9};
    Mout_Wdata_ram = 16'h7700;
    Mout_data_ram_size = 8'h80;
    tick();
    chk("rw_wr_rdy", 32'(M_DataRdy), 32'd2);
    Mout_oe_ram = 2'b00;
    Mout_we_ram = 2'b00;
    tick();
    chk("rw_rd_rdy", 32'(M_DataRdy), 32'd1);
    chk("rw_rd_old", 32'(M_Rdata_ram), 32'h0022);
    tick();
    do_read(0, 7'd9, 8'h77, "rw_new");

    // size 0 writes nothing
    do_write(0, 7'd9, 8'h55, 4'd0, "wr_sz0");
    do_read(1, 7'd9, 8'h77, "rd_sz0");

    // Out-of-range load is dropped silently (offset 100 must not alias offset 36)
    preload(7'd100, 8'h99);
    chk("oob_load_err", 32'(proto_err), 32'd0);
    do_read(0, 7'd36, 8'h12, "oob_load_rd");

    // Out-of-range request never completes
    Mout_oe_ram[0] = 1'b1;
    set_addr(0, 7'd64);
    seen = 0;
    repeat (10) begin
      tick();
      if (M_DataRdy != 2'b00) seen = 1;
    end
    chk("oor_no_rdy", 32'(seen), 32'd0);
    chk("oor_state", 32'(dbg_state), 32'd0);
    chk("oor_err", 32'(proto_err), 32'd0);
    Mout_oe_ram[0] = 1'b0;

    // oe and we together: sticky error, request ignored
    Mout_oe_ram[0] = 1'b1;
    Mout_we_ram[0] = 1'b1;
    set_addr(0, 7'd5);
    tick();
    chk("both_err", 32'(proto_err), 32'd1);
    chk("both_state", 32'(dbg_state), 32'd0);
    Mout_oe_ram[0] = 1'b0;
    Mout_we_ram[0] = 1'b0;
    seen = 0;
    repeat (3) begin
      tick();
      if (M_DataRdy != 2'b00) seen = 1;
    end
    chk("both_no_rdy", 32'(seen), 32'd0);
    chk("both_sticky", 32'(proto_err), 32'd1);

    // Reset in the middle of a read and a write
    Mout_oe_ram    = 2'b01;
    Mout_we_ram    = 2'b10;
    Mout_addr_ram  = {7'd7, 7'd5};
    Mout_Wdata_ram = 16'h5A00;
    Mout_data_ram_size = 8'h80;
    tick();
    chk("mid_wr_rdy", 32'(M_DataRdy), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(M_DataRdy), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    chk("mid_rst_err", 32'(proto_err), 32'd0);
    Mout_oe_ram = 2'b00;
    Mout_we_ram = 2'b00;
    tick();
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      tick();
      if (M_DataRdy != 2'b00) seen = 1;
    end
    chk("mid_no_rdy", 32'(seen), 32'd0);
    do_read(0, 7'd5, 8'hA5, "post_rst_rd");
    do_read(1, 7'd7, 8'h5A, "post_rst_wr");

    // Load while a channel is busy: error and dropped
    Mout_oe_ram[0] = 1'b1;
    set_addr(0, 7'd5);
    tick();
    chk("busy_pre_err", 32'(proto_err), 32'd0);
    load_en   = 1'b1;
    load_addr = 7'd5;
    load_data = 8'h00;
    tick();
    load_en = 1'b0;
    chk("busy_err", 32'(proto_err), 32'd1);
    chk("busy_rdy", 32'(M_DataRdy), 32'd1);
    chk("busy_data", 32'(M_Rdata_ram), 32'h00A5);
    Mout_oe_ram[0] = 1'b0;
    tick();
    do_read(0, 7'd5, 8'hA5, "busy_drop");

`ifdef EXT_MEM_ACCESS_CNT_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("cnt_rst_rd", rd_count, 32'd0);
    chk("cnt_rst_wr", wr_count, 32'd0);
    do_read(0, 7'd5, 8'hA5, "cnt_rd1");
    do_read(0, 7'd5, 8'hA5, "cnt_rd2");
    do_read(0, 7'd36, 8'h12, "cnt_rd3");
    Mout_we_ram    = 2'b11;
    Mout_addr_ram  = {7'd11, 7'd10};
    Mout_Wdata_ram = 16'hBBAA;
    Mout_data_ram_size = 8'h88;
    tick();
    Mout_we_ram = 2'b00;
    tick();
    chk("cnt_rd", rd_count, 32'd3);
    chk("cnt_wr", wr_count, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_mem_dual_channel_model.md
Name: ext_mem_dual_channel_model

Overview:
- Off-chip memory slave directly downstream of the HLS accelerator's two-channel master port (Mout_oe_ram / Mout_we_ram / Mout_addr_ram / Mout_Wdata_ram / Mout_data_ram_size).
- Returns M_Rdata_ram and M_DataRdy with programmable read and write latency.
- Replaces the behavioural memory model with a synthesizable, cycle-exact block usable both in simulation and on FPGA prototype.
- Each channel is byte-wide, has an independent latency FSM, and shares one byte array.

Parameters:
- ADDR_W, 7, address bits per channel
- MEMSIZE, 64, bytes in array (≤ 2^ADDR_W)
- BASE_ADDR, 0, first byte address served; requests outside [BASE_ADDR, BASE_ADDR+MEMSIZE) are ignored
- READ_DELAY, 2, cycles from read acceptance edge to DataRdy (≥1)
- WRITE_DELAY, 1, cycles from write acceptance edge to DataRdy (≥1)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- Mout_oe_ram  in  2  read request per channel
- Mout_we_ram  in  2  write request per channel
- Mout_addr_ram  in  2*ADDR_W  channel c address = bits [c*ADDR_W +: ADDR_W]
- Mout_Wdata_ram  in  16  write byte per channel
- Mout_data_ram_size  in  8  access size in bits, 4 bits per channel
- load_en  in  1  preload strobe
- load_addr  in  ADDR_W  preload offset (relative to BASE_ADDR)
- load_data  in  8  preload byte
- M_Rdata_ram  out  16  read byte per channel
- M_DataRdy  out  2  one-cycle completion pulse per channel
- proto_err  out  1  sticky protocol error

Behaviour:
- Reset: M_Rdata_ram = 0, M_DataRdy = 0, proto_err = 0, both FSMs IDLE, latency counters 0. Array contents are not reset.
- Per-channel FSM, states IDLE → RD_WAIT / WR_WAIT → IDLE.
- IDLE + oe=1 + in-range address at a rising edge (the acceptance edge):
  - capture array[addr-BASE_ADDR] into the channel holding register, cnt=1, go to RD_WAIT.
- IDLE + we=1 + in-range address at the acceptance edge:
  - array byte ← (Wdata & mask) | (old & ~mask); cnt=1; go to WR_WAIT.
  - mask = (1<<size)-1, size=0 gives no bits written, size≥8 gives 0xFF.
- WAIT states: cnt increments each edge. DataRdy=1 combinationally while cnt == DELAY. The next edge returns the channel to IDLE.
  - READ_DELAY=2: acceptance at edge 0, DataRdy high between edge 1 and edge 2.
- M_Rdata_ram byte c = holding register while DataRdy[c]=1, else 0.
- Requests are ignored while a channel is in a WAIT state; the master holds its request until DataRdy.
- Back-to-back: if the request is still asserted at the edge ending the DataRdy cycle, it is not accepted; acceptance happens on the following edge from IDLE.
- Out-of-range requests: no state change, DataRdy is never asserted, proto_err is not set.
- oe=1 and we=1 on the same channel at an edge: proto_err ← 1 (sticky until reset), request ignored.
- Both channels write the same byte on the same edge: channel 1 wins. Masks are not merged.
- Read and write to the same byte on the same edge: the read captures the old value.
- load_en: the array is written at the edge only if both FSMs are IDLE and there is no acceptance on that edge. Otherwise proto_err ← 1 and the load is dropped. load_addr ≥ MEMSIZE is dropped silently.
- Reset asserted mid-transaction: the pending DataRdy is lost and the FSMs return to IDLE. A write already committed at its acceptance edge remains in the array.

Optional Feature:
- Macro: EXT_MEM_ACCESS_CNT_EN.
- When defined:
  - adds outputs rd_count[31:0] and wr_count[31:0], reset to 0;
  - each accepted read or write (either channel) increments the respective counter at the acceptance edge;
  - simultaneous acceptances on both channels add 2;
  - counters saturate at 0xFFFFFFFF.
- When undefined: these ports and registers do not exist, and all other behaviour is identical.

Test Plan:
- Preload offset 5 = 0xA5, channel 0 oe at address 5, READ_DELAY=2 → M_DataRdy[0] pulses for exactly 1 cycle, 2 cycles after acceptance, with M_Rdata_ram[7:0]=0xA5. M_Rdata_ram[7:0]=0 in all other cycles.
- Offset 3 = 0xFF, channel 1 write 0x00 with size=4, then read → read returns 0xF0. DataRdy[1] arrives 1 cycle after write acceptance.
- Both channels write offset 9 on the same edge (ch0 0x11, ch1 0x22) → read returns 0x22. Both DataRdy bits pulse.
- Channel 0 oe=we=1 → proto_err=1, no DataRdy. proto_err stays 1 until reset. Request at address BASE_ADDR+MEMSIZE → no DataRdy within 10 cycles.
- Assert reset during RD_WAIT → DataRdy never pulses. Post-reset read of the same address completes normally. A write committed before reset persists.
- With EXT_MEM_ACCESS_CNT_EN: 3 reads on ch0 plus 2 simultaneous writes on ch0/ch1 → rd_count=3, wr_count=2.
